dram_write_arbiter: RTL

//  Sole write port driver for dram port A; replaces the start-selected mux trio in main.
//  CPU result writes are buffered in a small FIFO and drained when start=1.

---
 rtl/dram_arb_pkg.sv | 42 ++++
 rtl/wr_fifo.sv | 73 +++++++
 rtl/dram_write_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dram_arb_pkg.sv
// ============================================================================
//  Module   : dram_arb_pkg
//  Purpose  : Shared types and default widths for the dram port A write
//             arbiter (state encoding, write-request record, saturating
//             counter helper).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dram_arb_pkg;

  // Default widths used by the arbiter top
  localparam int unsigned ARB_ADDR_W = 18;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_DEPTH  = 4;

  // Arbiter state encoding (fixed 2-bit width)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_QUAD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DRAIN = ST_DRAIN,
    QUAD  = ST_QUAD
  } arb_state_t;

  // One buffered CPU write at the default widths
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
  } wr_req_t;

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wr_fifo.sv
// ============================================================================
//  Module   : wr_fifo
//  Purpose  : Parameterised synchronous FIFO holding pending CPU writes.
//             Push when not full, pop when not empty; simultaneous push and
//             pop leave the count unchanged. Head word is read combinationally.
//  Ports    : clock_i      clock
//             reset_i      synchronous reset, active-low
//             push_i       write request (ignored when full)
//             push_data_i  word to store
//             pop_i        remove head (ignored when empty)
//             head_o       oldest stored word
//             full_o       count == DEPTH
//             empty_o      count == 0
//             count_o      number of stored words
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wr_fifo #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the count alone
  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/dram_write_arbiter.sv
// ============================================================================
//  Module   : dram_write_arbiter
//  Purpose  : Sole driver of dram port A writes. CPU writes are queued in a
//             small FIFO and drained while start_i=1; while start_i=0 the
//             quadrant word is written to QUAD_ADDR whenever it changes and
//             once on every entry into config mode. RAM outputs registered.
//  Option   : DRAM_ARB_STATS_EN adds cpu_writes_o / overflow_o statistics.
//  Ports    : clock_i        clock
//             reset_i        synchronous reset, active-low
//             start_i        1 = run mode (drain FIFO), 0 = config mode
//             quadrant_i     current quadrant word
//             cpu_wen_i      CPU write request (taken when cpu_ready_o)
//             cpu_address_i  CPU write address
//             cpu_data_i     CPU write data
//             cpu_ready_o    FIFO not full
//             ram_address_o  dram address_a (registered)
//             ram_data_o     dram data_a (registered)
//             ram_wen_o      dram wren_a (registered, one pulse per word)
//             busy_o         FIFO non-empty or quadrant write pending
//             cpu_writes_o   [stats] saturating count of CPU words written
//             overflow_o     [stats] sticky: request seen while full
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_write_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned        ADDR_W    = ARB_ADDR_W,
  parameter int unsigned        DATA_W    = ARB_DATA_W,
  parameter int unsigned        DEPTH     = ARB_DEPTH,
  parameter logic [ADDR_W-1:0]  QUAD_ADDR = '0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] quadrant_i,
  input  logic              cpu_wen_i,
  input  logic [ADDR_W-1:0] cpu_address_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic              cpu_ready_o,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wen_o,
  output logic              busy_o
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_writes_o,
  output logic              overflow_o
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t        push_req;
  req_t        head_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        push;
  logic        pop;
  arb_state_t  state;

  logic              ram_wen_q,     ram_wen_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q,    ram_data_d;
  logic [DATA_W-1:0] shadow_q,      shadow_d;
  logic              pending_q,     pending_d;
  logic              start_q;

  assign push_req.addr = cpu_address_i;
  assign push_req.data = cpu_data_i;
  assign push          = cpu_wen_i && cpu_ready_o;
  assign pop           = (state == DRAIN);

  wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head_req),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Pending quadrant writes take priority over draining, but only one of
  // the two modes can ever be active since they depend on start_i.
  always_comb begin
    state = IDLE;
    if (!start_i && pending_q)      state = QUAD;
    else if (start_i && !fifo_empty) state = DRAIN;
  end

  always_comb begin
    ram_wen_d     = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    case (state)
      QUAD: begin
        ram_wen_d     = 1'b1;
        ram_address_d = QUAD_ADDR;
        ram_data_d    = quadrant_i;
        shadow_d      = quadrant_i;
        pending_d     = 1'b0;
      end
      DRAIN: begin
        ram_wen_d     = 1'b1;
        ram_address_d = head_req.addr;
        ram_data_d    = head_req.data;
      end
      default: ;
    endcase
    // A new request in config mode: quadrant moved, or we just left run mode
    // (quadrant changes made in run mode were never written).
    if (state != QUAD && !start_i && ((quadrant_i != shadow_q) || start_q))
      pending_d = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      ram_wen_q     <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b1;  // always publish the quadrant once after reset
      start_q       <= 1'b0;
    end else begin
      ram_wen_q     <= ram_wen_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      start_q       <= start_i;
    end
  end

  assign cpu_ready_o   = !fifo_full;
  assign ram_wen_o     = ram_wen_q;
  assign ram_address_o = ram_address_q;
  assign ram_data_o    = ram_data_q;
  assign busy_o        = (fifo_count != '0) || pending_q;

`ifdef DRAM_ARB_STATS_EN
  logic [15:0] cpu_writes_q;
  logic        overflow_q;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      cpu_writes_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (state == DRAIN)            cpu_writes_q <= sat_inc16(cpu_writes_q);
      if (cpu_wen_i && !cpu_ready_o) overflow_q   <= 1'b1;
    end
  end

  assign cpu_writes_o = cpu_writes_q;
  assign overflow_o   = overflow_q;
`endif

endmodule

`default_nettype wire
